// File: rtl/phase_derotator.sv
// phase_derotator
//   Removes a carrier phase offset from filtered I/Q samples by multiplying
//   each sample by e^(-j*theta).  theta comes from an internal NCO (phase
//   accumulator plus static offset) that drives a quarter-wave sin/cos table.
//   The module is fully pipelined: one sample per clock, 3-cycle latency,
//   with no backpressure.
//
// Ports
//   clock          system clock, rising edge
//   i_reset        synchronous reset, active-low
//   i_valid        input sample strobe
//   i_dataI/Q      input sample, S(8,6)
//   i_phase_inc    unsigned phase step added per valid sample
//   i_phase_off    static phase offset added to the accumulator
//   i_clear_phase  synchronous clear of the phase accumulator
//   o_valid        output sample strobe (one cycle per sample)
//   o_dataI/Q      derotated sample, S(8,6); holds between strobes
module phase_derotator #(
  parameter int NB_DATA   = 8,
  parameter int NBF_DATA  = 6,
  parameter int NB_COEFF  = 8,
  parameter int NBF_COEFF = 6,
  parameter int NB_PHASE  = 8
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic signed [NB_DATA-1:0]  i_dataI,
  input  logic signed [NB_DATA-1:0]  i_dataQ,
  input  logic        [NB_PHASE-1:0] i_phase_inc,
  input  logic        [NB_PHASE-1:0] i_phase_off,
  input  logic                       i_clear_phase,
  output logic                       o_valid,
  output logic signed [NB_DATA-1:0]  o_dataI,
  output logic signed [NB_DATA-1:0]  o_dataQ
);

  localparam int NB_PROD = NB_DATA + NB_COEFF;
  localparam int NB_SUM  = NB_PROD + 1;
  localparam int NBF_SUM = NBF_DATA + NBF_COEFF;
  localparam int SHIFT   = NBF_SUM - NBF_DATA;
  localparam int OUT_MSB = NB_DATA - 1 + SHIFT;
  localparam int NB_SEL  = 6;  // 2 quadrant bits + 4 table-index bits

  // Quarter-wave table: round(64*sin(k*pi/32)), k = 0..16.
  function automatic logic signed [NB_COEFF-1:0] quarter_sin(input logic [4:0] k);
    case (k)
      5'd0:    return NB_COEFF'(0);
      5'd1:    return NB_COEFF'(6);
      5'd2:    return NB_COEFF'(12);
      5'd3:    return NB_COEFF'(19);
      5'd4:    return NB_COEFF'(24);
      5'd5:    return NB_COEFF'(30);
      5'd6:    return NB_COEFF'(36);
      5'd7:    return NB_COEFF'(41);
      5'd8:    return NB_COEFF'(45);
      5'd9:    return NB_COEFF'(49);
      5'd10:   return NB_COEFF'(53);
      5'd11:   return NB_COEFF'(56);
      5'd12:   return NB_COEFF'(59);
      5'd13:   return NB_COEFF'(61);
      5'd14:   return NB_COEFF'(63);
      5'd15:   return NB_COEFF'(64);
      5'd16:   return NB_COEFF'(64);
      default: return NB_COEFF'(0);
    endcase
  endfunction

  // Drop SHIFT fraction bits (truncation) and clip to the output range when
  // the integer bits above the output MSB are not pure sign extension.
  function automatic logic signed [NB_DATA-1:0] sat_trunc(input logic signed [NB_SUM-1:0] s);
    logic [NB_SUM-OUT_MSB-1:0] top;
    top = s[NB_SUM-1:OUT_MSB];
    if ((&top) || !(|top))
      return s[OUT_MSB:SHIFT];
    else if (s[NB_SUM-1])
      return {1'b1, {(NB_DATA-1){1'b0}}};
    else
      return {1'b0, {(NB_DATA-1){1'b1}}};
  endfunction

  logic        [NB_PHASE-1:0] acc;
  logic        [NB_PHASE-1:0] acc_used;
  logic        [NB_SEL-1:0]   sel;
  logic        [1:0]          quad;
  logic        [4:0]          idx;
  logic        [4:0]          idx_c;
  logic signed [NB_COEFF-1:0] sin_c;
  logic signed [NB_COEFF-1:0] cos_c;

  // A clear in the same cycle as a sample makes that sample see acc = 0.
  assign acc_used = i_clear_phase ? '0 : acc;
  // theta[1:0] are dropped: only quadrant and table index are needed.
  assign sel      = NB_SEL'((acc_used + i_phase_off) >> (NB_PHASE - NB_SEL));
  assign quad     = sel[5:4];
  assign idx      = {1'b0, sel[3:0]};
  assign idx_c    = 5'd16 - idx;

  always_comb begin
    sin_c = '0;
    cos_c = '0;
    case (quad)
      2'd0: begin sin_c =  quarter_sin(idx);   cos_c =  quarter_sin(idx_c); end
      2'd1: begin sin_c =  quarter_sin(idx_c); cos_c = -quarter_sin(idx);   end
      2'd2: begin sin_c = -quarter_sin(idx);   cos_c = -quarter_sin(idx_c); end
      default: begin sin_c = -quarter_sin(idx_c); cos_c =  quarter_sin(idx); end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_reset)
      acc <= '0;
    else if (i_clear_phase)
      acc <= '0;
    else if (i_valid)
      acc <= acc + i_phase_inc;
  end

  // Stage 1: sample, coefficients and valid
  logic                       vld_p0;
  logic signed [NB_DATA-1:0]  di_p0, dq_p0;
  logic signed [NB_COEFF-1:0] sin_p0, cos_p0;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      vld_p0 <= 1'b0;
      di_p0  <= '0;
      dq_p0  <= '0;
      sin_p0 <= '0;
      cos_p0 <= '0;
    end else begin
      vld_p0 <= i_valid;
      di_p0  <= i_dataI;
      dq_p0  <= i_dataQ;
      sin_p0 <= sin_c;
      cos_p0 <= cos_c;
    end
  end

  // Stage 2: full-precision products
  logic                      vld_p1;
  logic signed [NB_PROD-1:0] ic_p1, qs_p1, qc_p1, is_p1;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      vld_p1 <= 1'b0;
      ic_p1  <= '0;
      qs_p1  <= '0;
      qc_p1  <= '0;
      is_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      ic_p1  <= di_p0 * cos_p0;
      qs_p1  <= dq_p0 * sin_p0;
      qc_p1  <= dq_p0 * cos_p0;
      is_p1  <= di_p0 * sin_p0;
    end
  end

  logic signed [NB_SUM-1:0] sum_i, sum_q;

  assign sum_i = {ic_p1[NB_PROD-1], ic_p1} + {qs_p1[NB_PROD-1], qs_p1};
  assign sum_q = {qc_p1[NB_PROD-1], qc_p1} - {is_p1[NB_PROD-1], is_p1};

  // Stage 3: quantised outputs, held between strobes
  logic                      vld_p2;
  logic signed [NB_DATA-1:0] di_p2, dq_p2;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      vld_p2 <= 1'b0;
      di_p2  <= '0;
      dq_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        di_p2 <= sat_trunc(sum_i);
        dq_p2 <= sat_trunc(sum_q);
      end
    end
  end

  assign o_valid = vld_p2;
  assign o_dataI = di_p2;
  assign o_dataQ = dq_p2;

endmodule
